// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control sequencer for a 5-stage core: RAW hazard stall, branch flush, memory freeze.
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
`ifdef STALL_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fwd_mode,
    input  logic [3:0] id_src1,
    input  logic       id_src1_vld,
    input  logic [3:0] id_src2,
    input  logic       id_src2_vld,
    input  logic [3:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_ren,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    input  logic       mem_busy,
    input  logic       branch_taken,
    output logic       hazard,
    output logic       bubble_id,
    output logic       flush,
    output logic       freeze_all,
    output logic [1:0] state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_e;

    // Counter only needs to hold FLUSH_CYCLES-1 remaining flush cycles.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_CYCLES - 1);

    state_e          state_r;
    state_e          state_nxt_s;
    logic [FC_W-1:0] cnt_r;
    logic [FC_W-1:0] cnt_nxt_s;
    logic            raw_e_s;
    logic            raw_m_s;
    logic            dh_s;
    logic            hazard_s;
    logic            flush_s;
    logic            freeze_s;

    function automatic logic src_hit(input logic [3:0] src1, input logic vld1,
                                     input logic [3:0] src2, input logic vld2,
                                     input logic [3:0] dest, input logic wb_en);
        return wb_en & ((vld1 & (src1 == dest)) | (vld2 & (src2 == dest)));
    endfunction

    assign raw_e_s = src_hit(id_src1, id_src1_vld, id_src2, id_src2_vld, exe_dest, exe_wb_en);
    assign raw_m_s = src_hit(id_src1, id_src1_vld, id_src2, id_src2_vld, mem_dest, mem_wb_en);
    assign dh_s    = fwd_mode ? (raw_e_s & exe_mem_ren) : (raw_e_s | raw_m_s);

    // Next-state and control outputs; WAIT re-applies RUN rules once memory is ready.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        hazard_s    = 1'b0;
        flush_s     = 1'b0;
        freeze_s    = 1'b0;
        if (rst) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_RUN, ST_WAIT: begin
                    if (mem_busy) begin
                        freeze_s    = 1'b1;
                        state_nxt_s = ST_WAIT;
                    end else if (branch_taken) begin
                        flush_s = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt_s = ST_FLUSH;
                            cnt_nxt_s   = FLUSH_INIT;
                        end else begin
                            state_nxt_s = ST_RUN;
                            cnt_nxt_s   = '0;
                        end
                    end else begin
                        hazard_s    = dh_s;
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (mem_busy) begin
                        freeze_s = 1'b1;
                    end else begin
                        flush_s = 1'b1;
                        if (cnt_r <= FC_W'(1)) begin
                            state_nxt_s = ST_RUN;
                            cnt_nxt_s   = '0;
                        end else begin
                            cnt_nxt_s = cnt_r - FC_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // State and flush-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign hazard     = hazard_s;
    assign bubble_id  = hazard_s;
    assign flush      = flush_s;
    assign freeze_all = freeze_s;
    assign state      = (rst || (state_r == ST_BAD)) ? 2'd0 : state_r;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles the pipeline lost to any stall source.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if ((hazard_s | flush_s | freeze_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a remaining-flush-count reference model.
module tb_pipeline_hazard_ctrl;

    localparam int FC      = 2;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst, fwd_mode, id_src1_vld, id_src2_vld, exe_wb_en, exe_mem_ren;
    logic       mem_wb_en, mem_busy, branch_taken;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       hazard, bubble_id, flush, freeze_all;
    logic [1:0] state;
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: expected state output, flush cycles still owed, stall count.
    int m_state = 0;
    int m_left  = 0;
    int m_cnt   = 0;

    typedef struct packed {
        logic       hz;
        logic       fl;
        logic       fr;
        logic [1:0] st;
    } exp_t;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .fwd_mode(fwd_mode),
        .id_src1(id_src1), .id_src1_vld(id_src1_vld),
        .id_src2(id_src2), .id_src2_vld(id_src2_vld),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_ren(exe_mem_ren),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_busy(mem_busy), .branch_taken(branch_taken),
        .hazard(hazard), .bubble_id(bubble_id), .flush(flush),
        .freeze_all(freeze_all), .state(state)
`ifdef STALL_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic bit data_hazard();
        bit re, rm;
        re = exe_wb_en && ((id_src1_vld && id_src1 == exe_dest) || (id_src2_vld && id_src2 == exe_dest));
        rm = mem_wb_en && ((id_src1_vld && id_src1 == mem_dest) || (id_src2_vld && id_src2 == mem_dest));
        return fwd_mode ? (re && exe_mem_ren) : (re || rm);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (!rst) begin
            e.st = 2'(m_state);
            if (mem_busy)          e.fr = 1'b1;
            else if (m_left > 0)   e.fl = 1'b1;
            else if (branch_taken) e.fl = 1'b1;
            else                   e.hz = data_hazard();
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Advance the reference model on each rising edge.
    always @(posedge clk) begin
        exp_t e;
        e = model_out();
        if (rst) begin
            m_state <= 0; m_left <= 0; m_cnt <= 0;
        end else begin
            if ((e.hz || e.fl || e.fr) && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            if (mem_busy) begin
                m_state <= (m_left > 0) ? 2 : 1;
            end else if (m_left > 0) begin
                m_left  <= m_left - 1;
                m_state <= (m_left - 1 > 0) ? 2 : 0;
            end else if (branch_taken) begin
                m_left  <= FC - 1;
                m_state <= (FC - 1 > 0) ? 2 : 0;
            end else begin
                m_state <= 0;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = model_out();
            chk("hazard",     int'(hazard),     int'(e.hz));
            chk("bubble_id",  int'(bubble_id),  int'(e.hz));
            chk("flush",      int'(flush),      int'(e.fl));
            chk("freeze_all", int'(freeze_all), int'(e.fr));
            chk("state",      int'(state),      int'(e.st));
`ifdef STALL_PERF_CNT_EN
            chk("stall_cnt",  int'(stall_cnt),  m_cnt);
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; fwd_mode = 1'b0; id_src1 = 4'd0; id_src1_vld = 1'b0;
        id_src2 = 4'd0; id_src2_vld = 1'b0; exe_dest = 4'd0; exe_wb_en = 1'b0;
        exe_mem_ren = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b0;
        mem_busy = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic load_use();
        fwd_mode = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_ren = 1'b1;
        id_src1 = 4'd3; id_src1_vld = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hazard", int'(hazard), 0);
        chk("rst_state",  int'(state),  0);
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_state", int'(state), 0);

        // Load-use stall and its removal.
        next_cycle(); load_use();
        @(negedge clk);
        chk("lu_hazard", int'(hazard), 1);
        chk("lu_bubble", int'(bubble_id), 1);
        next_cycle(); exe_mem_ren = 1'b0;
        @(negedge clk);
        chk("lu_noload", int'(hazard), 0);

        // Forwarding mode masks MEM-stage hazard.
        next_cycle(); idle();
        mem_dest = 4'd5; mem_wb_en = 1'b1; id_src2 = 4'd5; id_src2_vld = 1'b1;
        @(negedge clk);
        chk("fwd0_mem", int'(hazard), 1);
        next_cycle(); fwd_mode = 1'b1;
        @(negedge clk);
        chk("fwd1_mem", int'(hazard), 0);
        next_cycle(); id_src2_vld = 1'b0;
        @(negedge clk);
        chk("novld_fwd1", int'(hazard), 0);
        next_cycle(); fwd_mode = 1'b0;
        @(negedge clk);
        chk("novld_fwd0", int'(hazard), 0);

        // Branch flush with a pending hazard.
        next_cycle(); idle(); load_use(); branch_taken = 1'b1;
        @(negedge clk);
        chk("br_flush0", int'(flush), 1);
        chk("br_state0", int'(state), 0);
        chk("br_haz0",   int'(hazard), 0);
        next_cycle(); branch_taken = 1'b0;
        @(negedge clk);
        chk("br_flush1", int'(flush), 1);
        chk("br_state1", int'(state), 2);
        chk("br_haz1",   int'(hazard), 0);
        next_cycle();
        @(negedge clk);
        chk("br_flush2", int'(flush), 0);
        chk("br_state2", int'(state), 0);

        // Memory wait with pending load-use hazard.
        next_cycle(); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mw_freeze", int'(freeze_all), 1);
            chk("mw_haz",    int'(hazard), 0);
            if (i > 0) chk("mw_state", int'(state), 1);
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        chk("mw_release_haz",    int'(hazard), 1);
        chk("mw_release_freeze", int'(freeze_all), 0);

        // Memory wait in the second flush cycle.
        next_cycle(); idle(); branch_taken = 1'b1;
        next_cycle(); branch_taken = 1'b0; mem_busy = 1'b1;
        @(negedge clk);
        chk("fw_flush",  int'(flush), 0);
        chk("fw_freeze", int'(freeze_all), 1);
        next_cycle(); mem_busy = 1'b0;
        @(negedge clk);
        chk("fw_flush_resume", int'(flush), 1);
        chk("fw_state_resume", int'(state), 2);
        next_cycle();
        @(negedge clk);
        chk("fw_state_end", int'(state), 0);

        // Reset in the middle of a flush.
        next_cycle(); branch_taken = 1'b1;
        next_cycle(); branch_taken = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rf_flush", int'(flush), 0);
        chk("rf_state", int'(state), 0);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        chk("rf_state_after", int'(state), 0);
`ifdef STALL_PERF_CNT_EN
        chk("rf_cnt0", int'(stall_cnt), 0);
        load_use();
        for (int i = 0; i < 4; i++) next_cycle();
        idle();
        @(negedge clk);
        chk("rf_cnt4", int'(stall_cnt), 4);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst          = ($urandom_range(0, 99) == 0);
            fwd_mode     = 1'($urandom_range(0, 1));
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            id_src1_vld  = 1'($urandom_range(0, 1));
            id_src2_vld  = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_ren  = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_busy     = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 6) == 0);
        end
        next_cycle(); idle();
        @(negedge clk);
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
